// File: rtl/obi_periph_bridge_pkg.sv
// Shared types for the OBI-to-register-bus peripheral bridge.
// Latency: n/a (types, constants and a field-mapping helper only).
// Backpressure: n/a.
package obi_periph_bridge_pkg;

    localparam int unsigned ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;

    // One buffered OBI transaction; the req handshake bit is not stored.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } entry_t;

    function automatic entry_t obi_to_entry(input obi_req_t r);
        entry_t e;
        e.addr  = r.addr;
        e.we    = r.we;
        e.be    = r.be;
        e.wdata = r.wdata;
        return e;
    endfunction

endpackage

// File: rtl/obi_periph_bridge_reqq.sv
// Circular request queue of DEPTH entries; any DEPTH >= 1, pointers wrap at DEPTH.
// Latency: pushed entry visible at head_o the cycle after the push.
// Backpressure: full_o/empty_o; caller must not push when full nor pop when empty.
module obi_periph_bridge_reqq
    import obi_periph_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t push_dat_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: slots are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/obi_periph_bridge.sv
// OBI slave front-end: queues core requests, issues them one at a time on the reg bus, returns in-order responses.
// Latency: grant cycle 0 -> reg valid cycle 1 -> rvalid cycle 2 with immediate ready; 3 cycles per access back-to-back.
// Backpressure: gnt low while the queue is full; optional watchdog (OBI_PERIPH_BRIDGE_TIMEOUT_EN) aborts hung accesses.
module obi_periph_bridge
    import obi_periph_bridge_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t             slave_req_i,
    output obi_resp_t            slave_resp_o,
    output reg_req_t             reg_req_o,
    input  reg_rsp_t             reg_rsp_i,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_e               state_q;
    entry_t               acc_q;
    logic [31:0]          rdata_q;
    logic                 rvalid_q;
    logic                 timeout_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    entry_t head;
    logic   full, empty;
    logic   gnt, bypass, push, pop;
    logic   to_hit;
    logic   err_inc;

    // Grant depends only on the registered queue level, never on a same-cycle pop.
    assign gnt = slave_req_i.req & ~full;

    // With nothing queued and the FSM idle, a granted request goes straight into the
    // access register so the reg-bus access starts the very next cycle.
    assign bypass = (state_q == IDLE) & empty & gnt;
    assign push   = gnt & ~bypass;
    assign pop    = (state_q == IDLE) & ~empty;

    obi_periph_bridge_reqq #(
        .DEPTH(DEPTH)
    ) u_reqq (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .push_dat_i(obi_to_entry(slave_req_i)),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (full),
        .empty_o   (empty)
    );

`ifdef OBI_PERIPH_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counter holds the number of ACCESS cycles already elapsed; zero on entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q != ACCESS) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; a same-cycle ready takes priority.
    assign to_hit = (state_q == ACCESS) & ~reg_rsp_i.ready &
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: ACCESS waits for ready indefinitely and TIMEOUT_CYCLES has no effect.
    assign to_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    // Access FSM with registered response and timeout pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            rvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        acc_q   <= head;
                        state_q <= ACCESS;
                    end else if (bypass) begin
                        acc_q   <= obi_to_entry(slave_req_i);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (reg_rsp_i.ready) begin
                        if (acc_q.we) begin
                            rdata_q <= '0;
                        end else if (reg_rsp_i.error) begin
                            rdata_q <= ERR_RDATA;
                        end else begin
                            rdata_q <= reg_rsp_i.rdata;
                        end
                        rvalid_q <= 1'b1;
                        state_q  <= RESP;
                    end else if (to_hit) begin
                        rdata_q   <= ERR_RDATA;
                        rvalid_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign err_inc = ((state_q == ACCESS) & reg_rsp_i.ready & reg_rsp_i.error) | to_hit;

    // Saturating error counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = gnt;
        slave_resp_o.rvalid = rvalid_q;
        slave_resp_o.rdata  = rdata_q;

        reg_req_o       = '0;
        reg_req_o.valid = (state_q == ACCESS);
        reg_req_o.addr  = acc_q.addr;
        reg_req_o.write = acc_q.we;
        reg_req_o.wdata = acc_q.wdata;
        reg_req_o.wstrb = acc_q.be;
    end

    assign busy_o    = ~empty | (state_q != IDLE);
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_cnt_q;

endmodule
